chacha_stream_ctrl: RTL
=======================

// Module: chacha_stream_ctrl
// PURPOSE
//  Parametrised pin-side controller for the ChaCha core: byte/word-serial loading of key, nonce
//  and counter; launches the core; buffers the 512-bit keystream block; streams it out DATA_W bits
//  per cycle. Adds over the previous generation: configurable bus width, 64/96-bit nonce mode,
//  automatic counter increment with back-to-back blocks, and counter-wrap flag.
// PARAMETERS
//  DATA_W    8    serial bus width; legal 8, 16, 32
//  NONCE_W   96   96 = IETF (CTR_W=32); 64 = original (CTR_W=64); CTR_W = 128-NONCE_W
//  AUTO_CTR  1    1: counter += 1 after each fully streamed block; 0: counter static
// PORTS
//  clk        in   1        clock
//  rst        in   1        asynchronous reset, active-high
//  data_in    in   DATA_W   serial write data
//  wr_key     in   1        shift data_in into key
//  wr_nnc     in   1        shift data_in into nonce
//  wr_ctr     in   1        shift data_in into counter
//  rd_blk     in   1        request/consume keystream
//  hold       in   1        freeze all state this cycle
//  data_out   out  DATA_W   current keystream word
//  blk_ready  out  1        buffer holds unread keystream
//  ctr_wrap   out  1        sticky: counter wrapped all-ones -> 0
//  key        out  256      to core
//  nonce      out  NONCE_W  to core
//  counter    out  CTR_W    to core
//  core_start out  1        one-cycle launch pulse to core
//  core_done  in   1        one-cycle completion pulse from core
//  core_blk   in   512      core result, valid with core_done
// BEHAVIOUR
//  - Reset: all regs 0; state IDLE; data_out=0, blk_ready=0, ctr_wrap=0, core_start=0.
//  - Load regs shift right by DATA_W, data_in enters at MSB; after 256/DATA_W writes the first
//    word written sits at key[DATA_W-1:0] (little-endian, RFC 8439 byte order). Same for nonce/ctr.
//  - Write priority when several strobes high: key > nnc > ctr; only one register shifts.
//  - Writes accepted only in IDLE; ignored in RUN/READY/STREAM. Writes do not clear blk_ready.
//  - hold=1: no register, counter or state changes; core_done arriving under hold is still
//    captured (core pulse must not be lost); core_start is never issued under hold.
//  - FSM:
//    IDLE  : rd_blk & !hold -> core_start=1 next cycle, -> RUN.
//    RUN   : core_done -> buf <= core_blk, word index <= 0, blk_ready=1, -> READY.
//    READY : rd_blk & !hold -> -> STREAM (first word already on data_out).
//    STREAM: each rd_blk & !hold cycle: buf >>= DATA_W, index++. data_out = buf[DATA_W-1:0]
//            (registered, zero-latency from buffer). rd_blk low: pause, no change.
//            On consuming last word (index = 512/DATA_W-1): blk_ready=0; if AUTO_CTR counter
//            += 1 (mod 2^CTR_W, all-ones -> 0 sets ctr_wrap); then if AUTO_CTR & rd_blk still
//            high -> core_start, -> RUN (back-to-back); else -> IDLE.
//  - First word visible in READY before any consume; consume handshake = rd_blk & !hold & blk_ready.
//  - data_out holds last value in IDLE/RUN; is 0 after buffer fully shifted.
//  - core_start is exactly one cycle; no second start until core_done.
//  - ctr_wrap cleared only by reset or by a wr_ctr write.
//  - rst mid-operation: immediate return to reset state; in-flight core result discarded.
// STRUCTURE
//  - chacha_pkg: KEY_W=256, BLK_W=512, state enum {IDLE,RUN,READY,STREAM}, WORDS_PER_BLK(DATA_W)
//    function, legal-width assertions.
//  - Sub-module chacha_shift_in (params W, DATA_W, en, din, q): instantiated for key/nonce/ctr;
//    counter increment muxed outside it.
// TESTING
//  1 Reset mid-STREAM -> blk_ready=0, data_out=0, state IDLE, key/nonce/counter all 0.
//  2 DATA_W=8: write bytes 0x00..0x1f via wr_key -> key = 0x1f1e..0100; nonce 12 bytes, ctr=1.
//  3 RFC 8439 2.3.2 vector via core model: first data_out = 0x10, 64 bytes match, blk_ready drops
//    after byte 64, counter = 2.
//  4 AUTO_CTR=1, rd_blk held high: two blocks stream back-to-back, exactly two core_start pulses,
//    counter 1 -> 3; hold pulses mid-stream pause output with no dropped/duplicated byte.
//  5 NONCE_W=64, counter preset 0xFFFF_FFFF_FFFF_FFFF, stream one block -> counter=0, ctr_wrap=1.
//  6 wr_key & wr_ctr together in IDLE -> only key shifts; wr_key during RUN -> key unchanged.

Source files
------------

// File: rtl/chacha_stream_ctrl_pkg.sv
// Shared constants, FSM state type and parameter helpers for the ChaCha stream controller.
package chacha_stream_ctrl_pkg;

    localparam int KEY_W = 256;
    localparam int BLK_W = 512;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_READY  = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    function automatic int words_per_blk(input int data_w);
        return BLK_W / data_w;
    endfunction

    function automatic bit data_w_legal(input int data_w);
        return (data_w == 8) || (data_w == 16) || (data_w == 32);
    endfunction

    function automatic bit nonce_w_legal(input int nonce_w);
        return (nonce_w == 64) || (nonce_w == 96);
    endfunction

endpackage

// File: rtl/chacha_stream_ctrl_if.sv
// Pin-side serial bus of the ChaCha stream controller: load strobes, keystream read, status.
interface chacha_stream_ctrl_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              wr_key;
    logic              wr_nnc;
    logic              wr_ctr;
    logic              rd_blk;
    logic              hold;
    logic [DATA_W-1:0] data_out;
    logic              blk_ready;
    logic              ctr_wrap;

    modport master (
        output data_in, wr_key, wr_nnc, wr_ctr, rd_blk, hold,
        input  data_out, blk_ready, ctr_wrap
    );

    modport slave (
        input  data_in, wr_key, wr_nnc, wr_ctr, rd_blk, hold,
        output data_out, blk_ready, ctr_wrap
    );
endinterface

// File: rtl/chacha_stream_ctrl_shift_in.sv
// Serial load register: shifts right by DATA_W with new data entering at the MSB end.
// A parallel load (used for the counter increment) takes priority over the shift.
module chacha_shift_in #(
    parameter int W      = 256,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_ld,
    input  logic [W-1:0]      i_ld_val,
    output logic [W-1:0]      o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_ld_val;
        end else if (i_en) begin
            r_q <= {i_din, r_q[W-1:DATA_W]};
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/chacha_stream_ctrl.sv
// ChaCha core pin-side controller: serial key/nonce/counter load, core launch, keystream streaming.
//   state  | meaning
//   IDLE   | loads accepted; rd_blk launches the core
//   RUN    | core busy, waiting for core_done
//   READY  | block buffered, first word on data_out, nothing consumed yet
//   STREAM | block partially consumed
module chacha_stream_ctrl
    import chacha_stream_ctrl_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NONCE_W  = 96,
    parameter bit AUTO_CTR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    chacha_stream_ctrl_if.slave  bus,
    output logic [KEY_W-1:0]     o_key,
    output logic [NONCE_W-1:0]   o_nonce,
    output logic [127-NONCE_W:0] o_counter,
    output logic                 o_core_start,
    input  logic                 i_core_done,
    input  logic [BLK_W-1:0]     i_core_blk
);
    localparam int CTR_W   = 128 - NONCE_W;
    localparam int N_WORDS = words_per_blk(DATA_W);
    localparam int IDX_W   = $clog2(N_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam bit PARAMS_OK = data_w_legal(DATA_W) && nonce_w_legal(NONCE_W);

    state_t            r_state, w_state_nxt;
    logic [BLK_W-1:0]  r_buf;
    logic [DATA_W-1:0] r_data_out;
    logic [IDX_W-1:0]  r_idx;
    logic              r_blk_ready;
    logic              r_start;
    logic              r_got;
    logic              r_wrap;

    logic              w_launch, w_capture, w_consume, w_finish;
    logic              w_done_in_run, w_wr_ok;
    logic              w_en_key, w_en_nnc, w_en_ctr, w_ctr_inc;
    logic [CTR_W-1:0]  w_ctr_inc_val;

    a_params_legal: assert property (@(posedge clk) PARAMS_OK);

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_capture   = 1'b0;
        w_consume   = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rd_blk && !bus.hold) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.hold && (r_got || i_core_done)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY, ST_STREAM: begin
                if (bus.rd_blk && !bus.hold && r_blk_ready) begin
                    w_consume   = 1'b1;
                    w_state_nxt = ST_STREAM;
                    if (r_idx == LAST_IDX) begin
                        w_finish = 1'b1;
                        if (AUTO_CTR && bus.rd_blk) begin
                            w_launch    = 1'b1;
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_wr_ok       = (r_state == ST_IDLE) && !bus.hold;
    assign w_en_key      = w_wr_ok && bus.wr_key;
    assign w_en_nnc      = w_wr_ok && !bus.wr_key && bus.wr_nnc;
    assign w_en_ctr      = w_wr_ok && !bus.wr_key && !bus.wr_nnc && bus.wr_ctr;
    assign w_ctr_inc     = w_finish && AUTO_CTR;
    assign w_ctr_inc_val = o_counter + 1'b1;
    // The core pulse is latched even under hold so a completed block is never lost.
    assign w_done_in_run = (r_state == ST_RUN) && i_core_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_buf       <= '0;
            r_data_out  <= '0;
            r_idx       <= '0;
            r_blk_ready <= 1'b0;
            r_start     <= 1'b0;
            r_got       <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!bus.hold) begin
                r_start <= w_launch;
            end
            if (w_capture) begin
                r_got <= 1'b0;
            end else if (w_done_in_run) begin
                r_got <= 1'b1;
            end
            if (w_done_in_run) begin
                r_buf <= i_core_blk;
            end else if (w_consume) begin
                r_buf <= r_buf >> DATA_W;
            end
            if (w_capture) begin
                r_blk_ready <= 1'b1;
                r_idx       <= '0;
                r_data_out  <= i_core_done ? i_core_blk[DATA_W-1:0] : r_buf[DATA_W-1:0];
            end else if (w_consume) begin
                r_idx      <= r_idx + 1'b1;
                r_data_out <= r_buf[2*DATA_W-1:DATA_W];
                if (w_finish) begin
                    r_blk_ready <= 1'b0;
                end
            end
            if (w_en_ctr) begin
                r_wrap <= 1'b0;
            end else if (w_ctr_inc && (&o_counter)) begin
                r_wrap <= 1'b1;
            end
        end
    end

    chacha_shift_in #(.W(KEY_W), .DATA_W(DATA_W)) u_key (
        .clk(clk), .rst(rst), .i_en(w_en_key), .i_din(bus.data_in),
        .i_ld(1'b0), .i_ld_val('0), .o_q(o_key)
    );

    chacha_shift_in #(.W(NONCE_W), .DATA_W(DATA_W)) u_nonce (
        .clk(clk), .rst(rst), .i_en(w_en_nnc), .i_din(bus.data_in),
        .i_ld(1'b0), .i_ld_val('0), .o_q(o_nonce)
    );

    chacha_shift_in #(.W(CTR_W), .DATA_W(DATA_W)) u_ctr (
        .clk(clk), .rst(rst), .i_en(w_en_ctr), .i_din(bus.data_in),
        .i_ld(w_ctr_inc), .i_ld_val(w_ctr_inc_val), .o_q(o_counter)
    );

    assign bus.data_out  = r_data_out;
    assign bus.blk_ready = r_blk_ready;
    assign bus.ctr_wrap  = r_wrap;
    assign o_core_start  = r_start && !bus.hold;
endmodule
